// File: rtl/cnt_slot_arb_if.sv
// Request/grant bundle between requesting engines and the slot arbiter.
// The master side drives requests; the slave side (arbiter) returns grant and slot status.
interface cnt_slot_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [DATA_W-1:0] cnt_out;
  logic              busy;
  logic              slot_done;
  logic              rel_early;

  modport master (
    output req,
    input  gnt, gnt_id, cnt_out, busy, slot_done, rel_early
  );

  modport slave (
    input  req,
    output gnt, gnt_id, cnt_out, busy, slot_done, rel_early
  );
endinterface

// File: rtl/cnt_slot_arb.sv
// Round-robin arbiter time-sharing one slot counter (0..SLOT_LEN-1) among N_REQ requesters.
// States: IDLE | no grant, counter at 0 ; RUN | one requester owns the current slot
module cnt_slot_arb #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int SLOT_LEN = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  cnt_slot_arb_if.slave  bus
);
  localparam int ID_W = $clog2(N_REQ);
  localparam logic [DATA_W-1:0] CNT_LAST = DATA_W'(SLOT_LEN - 1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [ID_W-1:0]   gnt_id_q;
  logic [ID_W-1:0]   ptr_q;
  logic [DATA_W-1:0] cnt_q;

  logic              cnt_last;
  logic              end_cyc;
  logic              rel_cyc;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W-1:0]   arb_base;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]  req_rot;
  logic [ID_W-1:0]   win_off;
  logic [ID_W:0]     win_sum;
  logic              win_found;
  logic [ID_W-1:0]   win_d;
  logic [N_REQ-1:0]  gnt_d;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign end_cyc  = (state_q == RUN) && cnt_last;
  // A drop on the last slot cycle is a normal completion, not an early release.
  assign rel_cyc  = (state_q == RUN) && !bus.req[gnt_id_q] && !cnt_last;

  assign next_ptr = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + ID_W'(1);
  assign arb_base = (state_q == RUN) ? next_ptr : ptr_q;

  // Rotate requests so bit 0 is the pointer position, then take the first set bit.
  assign req_dbl = {bus.req, bus.req} >> arb_base;
  assign req_rot = req_dbl[N_REQ-1:0];

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        win_off   = ID_W'(i);
      end
    end
  end

  assign win_sum = {1'b0, arb_base} + {1'b0, win_off};
  assign win_d   = (win_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(win_sum - (ID_W+1)'(N_REQ))
                                                 : win_sum[ID_W-1:0];
  assign gnt_d   = N_REQ'(1) << win_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q  <= RUN;
            gnt_q    <= gnt_d;
            gnt_id_q <= win_d;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          if (end_cyc || rel_cyc) begin
            ptr_q <= next_ptr;
            cnt_q <= '0;
            if (win_found) begin
              gnt_q    <= gnt_d;
              gnt_id_q <= win_d;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + DATA_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.cnt_out   = cnt_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.slot_done = end_cyc;
  assign bus.rel_early = rel_cyc;
endmodule
